// File: rtl/pc_unit_if.sv
// Fetch-side bundle between pc_unit (master) and the hazard/branch logic and instruction ROM (slave).
// With PC_MISALIGN_EN defined, the bundle also carries misalign_err and bad_addr.
interface pc_unit_if #(
    parameter int PC_W = 32
);
    // Handshake: the fetch address advances on a clk edge only when inst_ready=1 and stall=0.
    // redirect_valid/exc_valid are single-cycle requests and need no acknowledge.
    logic            stall;
    logic            inst_ready;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_target;
    logic            exc_valid;
    logic [PC_W-1:0] pc;
    logic            inst_ce;
    logic [PC_W-1:0] pc_plus_step;
    logic            redirect_pending;
    logic            state_dbg;  // 0 = BOOT, 1 = FETCH
`ifdef PC_MISALIGN_EN
    logic            misalign_err;
    logic [PC_W-1:0] bad_addr;
`endif

    modport master (
        input  stall, inst_ready, redirect_valid, redirect_target, exc_valid,
        output pc, inst_ce, pc_plus_step, redirect_pending, state_dbg
`ifdef PC_MISALIGN_EN
        , output misalign_err, bad_addr
`endif
    );

    modport slave (
        output stall, inst_ready, redirect_valid, redirect_target, exc_valid,
        input  pc, inst_ce, pc_plus_step, redirect_pending, state_dbg
`ifdef PC_MISALIGN_EN
        , input misalign_err, bad_addr
`endif
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter: boot cycle, stall/ready hold, buffered redirects, exception vectoring.
// Optional PC_MISALIGN_EN: misaligned redirect targets trap to EXC_VEC instead of being silently aligned.
module pc_unit #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter int              STEP      = 4,
    parameter logic [31:0]     EXC_VEC   = 32'h0000_0380
) (
    input logic clk,
    input logic rst,
    pc_unit_if.master bus
);
    localparam logic [PC_W-1:0] STEP_V   = PC_W'(STEP);
    localparam logic [PC_W-1:0] LOW_MASK = PC_W'(STEP - 1);
    localparam logic [PC_W-1:0] EXC_ADDR = PC_W'(EXC_VEC);

    typedef enum logic {BOOT = 1'b0, FETCH = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            ce_q, ce_d;
    logic            pend_q, pend_d;
    logic [PC_W-1:0] ptgt_q, ptgt_d;
    logic            advance;
    logic [PC_W-1:0] target_al;
`ifdef PC_MISALIGN_EN
    logic            mis_q, mis_d;
    logic [PC_W-1:0] bad_q, bad_d;
    logic            target_bad;
`endif

    assign advance   = !bus.stall && bus.inst_ready;
    assign target_al = bus.redirect_target & ~LOW_MASK;
`ifdef PC_MISALIGN_EN
    assign target_bad = bus.redirect_valid && ((bus.redirect_target & LOW_MASK) != '0);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ce_d    = ce_q;
        pend_d  = pend_q;
        ptgt_d  = ptgt_q;
`ifdef PC_MISALIGN_EN
        mis_d   = 1'b0;
        bad_d   = bad_q;
`endif
        case (state_q)
            BOOT: begin
                state_d = FETCH;
                ce_d    = 1'b1;
            end
            FETCH: begin
                ce_d = 1'b1;
                if (bus.exc_valid) begin
                    // Exception overrides stall/ready and drops any concurrent redirect.
                    pc_d   = EXC_ADDR;
                    pend_d = 1'b0;
                end
`ifdef PC_MISALIGN_EN
                else if (target_bad) begin
                    pc_d   = EXC_ADDR;
                    pend_d = 1'b0;
                    bad_d  = bus.redirect_target;
                    mis_d  = 1'b1;
                end
`endif
                else if (advance && bus.redirect_valid) begin
                    pc_d   = target_al;
                    pend_d = 1'b0;
                end else if (advance && pend_q) begin
                    pc_d   = ptgt_q;
                    pend_d = 1'b0;
                end else if (advance) begin
                    pc_d = pc_q + STEP_V;
                end else if (bus.redirect_valid) begin
                    // Held fetch: remember the newest redirect until the PC can move.
                    pend_d = 1'b1;
                    ptgt_d = target_al;
                end
            end
            default: begin
                state_d = BOOT;
                ce_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            ce_q    <= 1'b0;
            pend_q  <= 1'b0;
            ptgt_q  <= '0;
`ifdef PC_MISALIGN_EN
            mis_q   <= 1'b0;
            bad_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ce_q    <= ce_d;
            pend_q  <= pend_d;
            ptgt_q  <= ptgt_d;
`ifdef PC_MISALIGN_EN
            mis_q   <= mis_d;
            bad_q   <= bad_d;
`endif
        end
    end

    assign bus.pc               = pc_q;
    assign bus.inst_ce          = ce_q;
    assign bus.pc_plus_step     = pc_q + STEP_V;
    assign bus.redirect_pending = pend_q;
    assign bus.state_dbg        = (state_q == FETCH);
`ifdef PC_MISALIGN_EN
    assign bus.misalign_err     = mis_q;
    assign bus.bad_addr         = bad_q;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit default instance and an 8-bit instance for wrap/alignment.
// Expected values are queued as each step is driven and popped when the DUT output is sampled.
module tb_pc_unit;
    localparam int W32 = 35;  // {pc[31:0], ce, pend, state}
    localparam int W8  = 19;  // {pc[7:0], ce, pend, mis, bad[7:0]}

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [W32-1:0] exp_q[$];
    logic [W8-1:0]  exp8_q[$];

    pc_unit_if #(.PC_W(32)) bus32 ();
    pc_unit_if #(.PC_W(8))  bus8 ();

    pc_unit #(.PC_W(32)) u32 (.clk(clk), .rst(rst), .bus(bus32));
    pc_unit #(.PC_W(8), .RESET_VEC(8'h00), .STEP(4), .EXC_VEC(32'h0000_0380))
        u8 (.clk(clk), .rst(rst), .bus(bus8));

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard
    task automatic chk32(input string tag);
        logic [W32-1:0] e;
        if (exp_q.size() == 0) begin
            cmp({tag, "_qempty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        cmp({tag, "_pc"},   bus32.pc, e[34:3]);
        cmp({tag, "_ce"},   32'(bus32.inst_ce), 32'(e[2]));
        cmp({tag, "_pend"}, 32'(bus32.redirect_pending), 32'(e[1]));
        cmp({tag, "_st"},   32'(bus32.state_dbg), 32'(e[0]));
        cmp({tag, "_pps"},  bus32.pc_plus_step, e[34:3] + 32'd4);
    endtask

    task automatic chk8(input string tag);
        logic [W8-1:0] e;
        logic [7:0]    nxt;
        if (exp8_q.size() == 0) begin
            cmp({tag, "_qempty"}, 32'd1, 32'd0);
            return;
        end
        e   = exp8_q.pop_front();
        nxt = e[18:11] + 8'd4;
        cmp({tag, "_pc"},   32'(bus8.pc), 32'(e[18:11]));
        cmp({tag, "_ce"},   32'(bus8.inst_ce), 32'(e[10]));
        cmp({tag, "_pend"}, 32'(bus8.redirect_pending), 32'(e[9]));
        cmp({tag, "_pps"},  32'(bus8.pc_plus_step), 32'(nxt));
`ifdef PC_MISALIGN_EN
        cmp({tag, "_mis"},  32'(bus8.misalign_err), 32'(e[8]));
        cmp({tag, "_bad"},  32'(bus8.bad_addr), 32'(e[7:0]));
`endif
    endtask

    // driver tasks
    task automatic now32(input string tag, input logic [31:0] p, input logic ce,
                         input logic pd, input logic st);
        exp_q.push_back({p, ce, pd, st});
        chk32(tag);
    endtask

    task automatic cyc32(input string tag, input logic [31:0] p, input logic pd);
        exp_q.push_back({p, 1'b1, pd, 1'b1});
        tick();
        chk32(tag);
    endtask

    task automatic cyc8(input string tag, input logic [7:0] p, input logic mis,
                        input logic [7:0] bad);
        exp8_q.push_back({p, 1'b1, 1'b0, mis, bad});
        tick();
        chk8(tag);
    endtask

    task automatic drive32(input logic st, input logic rdy, input logic rv,
                           input logic [31:0] tgt, input logic ex);
        bus32.stall           = st;
        bus32.inst_ready      = rdy;
        bus32.redirect_valid  = rv;
        bus32.redirect_target = tgt;
        bus32.exc_valid       = ex;
    endtask

    task automatic drive8(input logic st, input logic rv, input logic [7:0] tgt,
                          input logic ex);
        bus8.stall           = st;
        bus8.inst_ready      = 1'b1;
        bus8.redirect_valid  = rv;
        bus8.redirect_target = tgt;
        bus8.exc_valid       = ex;
    endtask

    initial begin
        drive32(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        drive8(1'b1, 1'b0, 8'h00, 1'b0);

        // reset and boot
        repeat (3) tick();
        now32("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        exp8_q.push_back({8'h00, 1'b0, 1'b0, 1'b0, 8'h00});
        chk8("reset8");
        rst = 1'b0;
        now32("pre_boot", 32'h0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({32'h0, 1'b1, 1'b0, 1'b1});
        tick();
        chk32("boot");
        cyc32("seq4", 32'h4, 1'b0);
        cyc32("seq8", 32'h8, 1'b0);

        // stall, then inst_ready low
        drive32(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc32("stall_a", 32'h8, 1'b0);
        cyc32("stall_b", 32'h8, 1'b0);
        drive32(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc32("stall_rel", 32'hC, 1'b0);
        drive32(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc32("nrdy_a", 32'hC, 1'b0);
        cyc32("nrdy_b", 32'hC, 1'b0);
        drive32(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc32("nrdy_rel", 32'h10, 1'b0);

        // buffered redirect
        drive32(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
        cyc32("buf_take", 32'h10, 1'b1);
        drive32(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc32("buf_hold_a", 32'h10, 1'b1);
        cyc32("buf_hold_b", 32'h10, 1'b1);
        drive32(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc32("buf_apply", 32'h100, 1'b0);
        cyc32("buf_next", 32'h104, 1'b0);

        // priority: exception over redirect, new redirect over pending
        drive32(1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
        cyc32("exc_vs_rd", 32'h380, 1'b0);
        drive32(1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
        cyc32("pend300", 32'h380, 1'b1);
        drive32(1'b0, 1'b1, 1'b1, 32'h400, 1'b0);
        cyc32("new_beats_pend", 32'h400, 1'b0);
        drive32(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc32("after400", 32'h404, 1'b0);

        // later buffered redirect overwrites the earlier one
        drive32(1'b1, 1'b1, 1'b1, 32'h500, 1'b0);
        cyc32("ovw_a", 32'h404, 1'b1);
        drive32(1'b1, 1'b1, 1'b1, 32'h600, 1'b0);
        cyc32("ovw_b", 32'h404, 1'b1);
        drive32(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc32("ovw_apply", 32'h600, 1'b0);

        // exception while stalled flushes a pending redirect
        drive32(1'b1, 1'b1, 1'b1, 32'h700, 1'b0);
        cyc32("exc_pend", 32'h600, 1'b1);
        drive32(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        cyc32("exc_stalled", 32'h380, 1'b0);
        drive32(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc32("exc_next", 32'h384, 1'b0);

        // misaligned 32-bit target
        drive32(1'b0, 1'b1, 1'b1, 32'h502, 1'b0);
`ifdef PC_MISALIGN_EN
        cyc32("mis32", 32'h380, 1'b0);
        drive32(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc32("mis32_next", 32'h384, 1'b0);
`else
        cyc32("align32", 32'h500, 1'b0);
        drive32(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc32("align32_next", 32'h504, 1'b0);
`endif

        // asynchronous reset with a pending redirect
        drive32(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
        cyc32("to40", 32'h40, 1'b0);
        drive32(1'b1, 1'b1, 1'b1, 32'h80, 1'b0);
        cyc32("pend80", 32'h40, 1'b1);
        drive32(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        #2 rst = 1'b1;
        #1;
        now32("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        now32("rst_held", 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        exp_q.push_back({32'h0, 1'b1, 1'b0, 1'b1});
        tick();
        chk32("reboot");
        cyc32("reboot4", 32'h4, 1'b0);

        // 8-bit wrap and alignment
        drive8(1'b0, 1'b1, 8'hFC, 1'b0);
        cyc8("to_fc", 8'hFC, 1'b0, 8'h00);
        drive8(1'b0, 1'b0, 8'h00, 1'b0);
        cyc8("wrap", 8'h00, 1'b0, 8'h00);
        drive8(1'b0, 1'b1, 8'h13, 1'b0);
`ifdef PC_MISALIGN_EN
        cyc8("mis8", 8'h80, 1'b1, 8'h13);
        drive8(1'b0, 1'b0, 8'h00, 1'b0);
        cyc8("mis8_pulse", 8'h84, 1'b0, 8'h13);
        drive8(1'b1, 1'b1, 8'h13, 1'b0);
        cyc8("mis8_stalled", 8'h80, 1'b1, 8'h13);
        drive8(1'b0, 1'b1, 8'h27, 1'b1);
        cyc8("exc_over_mis", 8'h80, 1'b0, 8'h13);
`else
        cyc8("align8", 8'h10, 1'b0, 8'h00);
        drive8(1'b0, 1'b0, 8'h00, 1'b0);
        cyc8("align8_next", 8'h14, 1'b0, 8'h00);
        drive8(1'b0, 1'b1, 8'h27, 1'b1);
        cyc8("exc8", 8'h80, 1'b0, 8'h00);
`endif
        drive8(1'b1, 1'b0, 8'h00, 1'b0);

        // final report
        cmp("sb_drain32", 32'(exp_q.size()), 32'd0);
        cmp("sb_drain8", 32'(exp8_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program counter for the fetch stage. Successor to the fixed 32-bit free-running PC.
- Adds:
  - configurable width, reset vector and step
  - a boot cycle after reset
  - stall and instruction-memory ready handshake
  - branch/jump redirect, buffered while fetch is held
  - exception vectoring
- Drives the instruction-memory address and chip enable. Sits between the hazard/branch logic and the instruction ROM.

Parameters:
- PC_W, 32, width of pc and all address ports.
- RESET_VEC, 0, pc value while in reset and during the BOOT cycle.
- STEP, 4, sequential increment in bytes. Must be a power of two, >= 4.
- EXC_VEC, 32'h0000_0380, exception entry address, truncated to PC_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hold pc (hazard unit).
- inst_ready  in  1  instruction memory accepted current address.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  PC_W  branch/jump destination.
- exc_valid  in  1  exception request; flushes and vectors.
- pc  out  PC_W  current fetch address (registered).
- inst_ce  out  1  instruction memory enable (registered).
- pc_plus_step  out  PC_W  combinational pc+STEP, mod 2^PC_W, for link registers.
- redirect_pending  out  1  a buffered redirect is waiting (registered).

Behaviour:
- Reset state while rst=1, asynchronous:
  - pc=RESET_VEC, inst_ce=0, redirect_pending=0, pending target=0
  - FSM=BOOT
- FSM states: BOOT, FETCH.
  - BOOT lasts exactly one clk edge after rst falls, then goes to FETCH. inst_ce=1 is registered on that edge.
  - In BOOT, pc holds RESET_VEC and all inputs except rst are ignored.
  - FETCH is permanent until reset.
- In FETCH, advance = !stall && inst_ready.
- Next-pc priority on each clk edge in FETCH, highest first:
  1. exc_valid=1: pc<=EXC_VEC, pending cleared. Ignores stall and inst_ready.
  2. advance && redirect_valid: pc<=redirect_target, pending cleared. A new redirect beats an older pending one.
  3. advance && redirect_pending: pc<=pending target, pending cleared.
  4. advance: pc<=pc+STEP, wrapping mod 2^PC_W (e.g. PC_W=32, pc=FFFF_FFFC -> 0000_0000).
  5. !advance && redirect_valid: pc holds; pending<=1, pending target<=redirect_target. A later redirect overwrites the earlier one.
  6. Otherwise pc holds.
- Latency: one cycle from an advance, redirect or exception to the new pc.
- inst_ce:
  - 1 in FETCH, including while stalled; memory re-reads the same address.
  - 0 only in reset and BOOT.
- Target alignment (macro off): the low log2(STEP) bits of redirect_target are forced to 0 before use or buffering.
- Reset mid-operation: pending redirect is discarded and pc returns to RESET_VEC immediately, without waiting for a clock.
- exc_valid and redirect_valid together: exception wins and the redirect is dropped, not buffered.

Optional Feature:
- Macro PC_MISALIGN_EN.
- Defined:
  - Adds output misalign_err (1 bit) and output bad_addr (PC_W bits), both reset to 0.
  - A redirect_valid whose target has nonzero low log2(STEP) bits (whether applied now or buffered) is not taken and not buffered.
  - Instead, on that edge: pc<=EXC_VEC, pending cleared, bad_addr<=target, misalign_err=1 for exactly one cycle.
  - This applies even if stalled.
  - exc_valid still has priority: misalign_err is not raised and bad_addr is unchanged.
- Undefined: ports are absent and targets are silently aligned as described in Behaviour.

Test Plan:
- Reset and boot: rst 1 for 3 cycles, then 0, with defaults.
  - pc=0 and inst_ce=0 during reset and the first post-reset edge.
  - Then inst_ce=1 and pc 0 -> 4 -> 8 -> C on successive edges with inst_ready=1.
- Stall: at pc=8, stall=1 for 2 cycles.
  - pc holds 8 and inst_ce=1 throughout.
  - Release gives pc=C. Repeat with inst_ready=0 instead of stall: same result.
- Buffered redirect: at pc=10, stall=1, redirect_valid=1 with target 100 for one cycle, then stall for 2 more cycles.
  - redirect_pending=1 and pc=10 while stalled.
  - After release, pc=100, pending=0, then pc=104.
- Priority: redirect_valid=1 (target 200) and exc_valid=1 in the same cycle.
  - pc=380, pending=0.
  - Next cycle, with a buffered pending 300 and redirect_valid target 400 on advance: pc=400.
- Wrap and alignment: PC_W=8, STEP=4, pc=FC, advance -> pc=00.
  - Redirect to 0x13 with macro off -> pc=0x10.
  - Same redirect with PC_MISALIGN_EN -> pc=0x80 (EXC_VEC truncated to 8 bits), bad_addr=0x13, misalign_err pulses 1 cycle.
- Asynchronous reset mid-run: pending=1 at pc=40, rst pulses between clock edges.
  - pc=0, inst_ce=0, pending=0 immediately.
  - Normal boot sequence follows.
